// File: rtl/pipeline_sequencer.sv
// pipeline_sequencer: one-hot / binary phase sequencer for the core pipeline.
// Walks phases 0..NUM_STATES-1 and wraps to 0. Supports skipping phases, holding on stall,
// flushing back to phase 0, and a global enable that freezes everything.
// The stateIndex output doubles as the externally visible FSM state.
// Optional feature: define PERF_COUNTER_EN to add retired-instruction and stall-cycle counters,
// along with their ports (instRetired, stallCycles, countClear).
module pipeline_sequencer #(
  parameter int NUM_STATES = 7,
  parameter int STATE_W    = 3
`ifdef PERF_COUNTER_EN
  ,
  parameter int CNT_W      = 32
`endif
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  stall,
  input  logic                  flush,
  input  logic [NUM_STATES-1:0] skipMask,
  output logic [NUM_STATES-1:0] stateOneHot,
  output logic [STATE_W-1:0]    stateIndex,
  output logic                  retire
`ifdef PERF_COUNTER_EN
  ,
  input  logic                  countClear,
  output logic [CNT_W-1:0]      instRetired,
  output logic [CNT_W-1:0]      stallCycles
`endif
);

  logic [31:0]           curWide;
  logic                  isIllegal;
  logic [STATE_W-1:0]    advIndex;
  logic [STATE_W-1:0]    nextIndex;
  logic [NUM_STATES-1:0] nextOneHot;
  logic                  canAdvance;

  // The index is widened before comparing. With a power-of-two NUM_STATES, a STATE_W-wide
  // constant would truncate to zero and make every state look illegal.
  assign curWide   = 32'(stateIndex);
  assign isIllegal = (curWide >= 32'(NUM_STATES));

  // An advance is possible only when enabled, not flushing, not stalling and in a legal phase.
  assign canAdvance = enable & ~flush & ~stall & ~isIllegal;

  // Find the lowest unskipped phase above the current one. The default of 0 gives the wrap.
  // Bit 0 of skipMask never satisfies j > current, so phase 0 can never be skipped.
  always_comb begin
    advIndex = '0;
    for (int j = NUM_STATES - 1; j >= 0; j--) begin
      if ((32'(j) > curWide) && !skipMask[j]) begin
        advIndex = STATE_W'(j);
      end
    end
  end

  // Next-state selection. Priority: enable, then flush or illegal (go to 0), then stall, then advance.
  always_comb begin
    nextIndex = stateIndex;
    if (enable) begin
      if (flush || isIllegal) begin
        nextIndex = '0;
      end else if (!stall) begin
        nextIndex = advIndex;
      end
    end
    nextOneHot = {{(NUM_STATES-1){1'b0}}, 1'b1} << nextIndex;
  end

  // State register. Index and one-hot are updated together, so they always agree.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stateIndex  <= '0;
      stateOneHot <= {{(NUM_STATES-1){1'b0}}, 1'b1};
    end else begin
      stateIndex  <= nextIndex;
      stateOneHot <= nextOneHot;
    end
  end

  // Retire pulse: this cycle wraps into phase 0 through a normal advance. It is held low in reset.
  always_comb begin
    retire = reset & canAdvance & (advIndex == '0);
  end

`ifdef PERF_COUNTER_EN
  logic stallEvent;
  assign stallEvent = enable & stall & ~flush;

  // Performance counters. countClear takes priority over increment, and both counters wrap.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      instRetired <= '0;
      stallCycles <= '0;
    end else if (countClear) begin
      instRetired <= '0;
      stallCycles <= '0;
    end else begin
      if (retire)     instRetired <= instRetired + CNT_W'(1);
      if (stallEvent) stallCycles <= stallCycles + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Directed testbench for pipeline_sequencer (NUM_STATES=7), with counter checks when
// PERF_COUNTER_EN is defined (counters are built 4 bits wide here).
module tb_pipeline_sequencer;

  localparam int NS = 7;
  localparam int SW = 3;
`ifdef PERF_COUNTER_EN
  localparam int CW = 4;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          enable;
  logic          stall;
  logic          flush;
  logic [NS-1:0] skipMask;
  logic [NS-1:0] stateOneHot;
  logic [SW-1:0] stateIndex;
  logic          retire;
`ifdef PERF_COUNTER_EN
  logic          countClear;
  logic [CW-1:0] instRetired;
  logic [CW-1:0] stallCycles;
`endif

  int checks = 0;
  int errors = 0;

  // Clock generation
  always #5 clk = ~clk;

  pipeline_sequencer #(
    .NUM_STATES (NS),
    .STATE_W    (SW)
`ifdef PERF_COUNTER_EN
    ,
    .CNT_W      (CW)
`endif
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .stall       (stall),
    .flush       (flush),
    .skipMask    (skipMask),
    .stateOneHot (stateOneHot),
    .stateIndex  (stateIndex),
    .retire      (retire)
`ifdef PERF_COUNTER_EN
    ,
    .countClear  (countClear),
    .instRetired (instRetired),
    .stallCycles (stallCycles)
`endif
  );

  task automatic checkVal(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  task automatic checkState(input string tag, input int idx);
    checkVal({tag, "_idx"}, 32'(stateIndex), 32'(idx));
    checkVal({tag, "_oh"}, 32'(stateOneHot), 32'(1) << idx);
  endtask

  // Called at a negedge with inputs already set. It checks retire, clocks one edge,
  // checks the new state, and then returns at the following negedge.
  task automatic stepCheck(input string tag, input logic expRetire, input int expIdx);
    #1;
    checkVal({tag, "_ret"}, 32'(retire), 32'(expRetire));
    @(posedge clk);
    #1;
    checkState(tag, expIdx);
    @(negedge clk);
  endtask

  initial begin
    // Reset. skipMask is chosen so that retire would fire if it were not gated by reset.
    reset    = 1'b0;
    enable   = 1'b1;
    stall    = 1'b0;
    flush    = 1'b0;
    skipMask = 7'b1111110;
`ifdef PERF_COUNTER_EN
    countClear = 1'b0;
`endif
    repeat (2) @(negedge clk);
    #1;
    checkState("reset", 0);
    checkVal("reset_ret", 32'(retire), 32'd0);
`ifdef PERF_COUNTER_EN
    checkVal("reset_inst", 32'(instRetired), 32'd0);
    checkVal("reset_stall", 32'(stallCycles), 32'd0);
`endif
    @(negedge clk);
    reset    = 1'b1;
    skipMask = '0;

    // Test 1: full sequence 0..6 twice. Retire occurs only from index 6.
    for (int i = 0; i < 14; i++) stepCheck("t1", (i % 7) == 6, (i + 1) % 7);

    // Test 2: phase 6 skipped. This gives a 6-cycle loop with retire from index 5.
    skipMask = 7'b1000000;
    for (int i = 0; i < 12; i++) stepCheck("t2", (i % 6) == 5, (i + 1) % 6);

    // Test 3: phases 2..4 are crossed in one cycle, then the sequencer stalls at 5.
`ifdef PERF_COUNTER_EN
    countClear = 1'b1;
`endif
    skipMask = 7'b0011100;
    stepCheck("t3a", 1'b0, 1);
`ifdef PERF_COUNTER_EN
    countClear = 1'b0;
`endif
    stepCheck("t3skip", 1'b0, 5);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) stepCheck("t3stall", 1'b0, 5);
`ifdef PERF_COUNTER_EN
    checkVal("t3_stallcnt", 32'(stallCycles), 32'd3);
    checkVal("t3_instcnt", 32'(instRetired), 32'd0);
`endif
    stall = 1'b0;
    stepCheck("t3c", 1'b0, 6);
    stepCheck("t3wrap", 1'b1, 0);
`ifdef PERF_COUNTER_EN
    checkVal("t3_inst1", 32'(instRetired), 32'd1);
`endif

    // Test 4: flush together with stall at index 4, then a flush while already in phase 0.
    skipMask = '0;
    for (int i = 0; i < 4; i++) stepCheck("t4adv", 1'b0, i + 1);
    stall = 1'b1;
    flush = 1'b1;
    stepCheck("t4flush", 1'b0, 0);
`ifdef PERF_COUNTER_EN
    checkVal("t4_inst", 32'(instRetired), 32'd1);
    checkVal("t4_stallcnt", 32'(stallCycles), 32'd3);
`endif
    stall = 1'b0;
    stepCheck("t4flush0", 1'b0, 0);
    flush = 1'b0;

    // Test 5: asynchronous reset at index 3, between clock edges.
    for (int i = 0; i < 3; i++) stepCheck("t5adv", 1'b0, i + 1);
    #2;
    reset  = 1'b0;
    enable = 1'b0;
    #1;
    checkState("t5async", 0);
`ifdef PERF_COUNTER_EN
    checkVal("t5_inst", 32'(instRetired), 32'd0);
    checkVal("t5_stallcnt", 32'(stallCycles), 32'd0);
`endif
    @(negedge clk);
    reset = 1'b1;
    stepCheck("t5hold", 1'b0, 0);
    stepCheck("t5hold", 1'b0, 0);
    enable = 1'b1;
    stepCheck("t5first", 1'b0, 1);
    for (int i = 1; i < 6; i++) stepCheck("t5run", 1'b0, i + 1);
    // With enable low at phase 6, the state freezes and retire stays low.
    enable = 1'b0;
    stepCheck("t5en0", 1'b0, 6);
    enable = 1'b1;
    stepCheck("t5wrap", 1'b1, 0);

`ifdef PERF_COUNTER_EN
    // Test 6: instRetired wraps after 16 retires, and countClear beats a simultaneous retire.
    countClear = 1'b1;
    stepCheck("t6clr", 1'b0, 1);
    checkVal("t6_clr_inst", 32'(instRetired), 32'd0);
    countClear = 1'b0;
    skipMask   = 7'b1111110;
    for (int i = 0; i < 16; i++) begin
      stepCheck("t6ret", 1'b1, 0);
      if (i == 14) checkVal("t6_inst15", 32'(instRetired), 32'd15);
    end
    checkVal("t6_wrap", 32'(instRetired), 32'd0);
    stepCheck("t6ret", 1'b1, 0);
    checkVal("t6_inst1", 32'(instRetired), 32'd1);
    countClear = 1'b1;
    stepCheck("t6clrret", 1'b1, 0);
    checkVal("t6_clr_prio", 32'(instRetired), 32'd0);
    checkVal("t6_clr_stall", 32'(stallCycles), 32'd0);
    countClear = 1'b0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
